// File: rtl/flex_srx_frame_if.sv
// Bus between a serial frame receiver and its line driver / consumer.
// With SRX_PARITY_EN defined the bus also carries parity_error.
interface flex_srx_frame_if #(
  parameter int NUM_BITS = 8
);
  logic                shift_strobe;
  logic                serial_in;
  logic                data_read;
  logic [NUM_BITS-1:0] rx_data;
  logic                data_ready;
  logic                framing_error;
  logic                overrun_error;
`ifdef SRX_PARITY_EN
  logic                parity_error;

  modport master (output shift_strobe, serial_in, data_read,
                  input  rx_data, data_ready, framing_error, overrun_error, parity_error);
  modport slave  (input  shift_strobe, serial_in, data_read,
                  output rx_data, data_ready, framing_error, overrun_error, parity_error);
`else
  modport master (output shift_strobe, serial_in, data_read,
                  input  rx_data, data_ready, framing_error, overrun_error);
  modport slave  (input  shift_strobe, serial_in, data_read,
                  output rx_data, data_ready, framing_error, overrun_error);
`endif
endinterface

// File: rtl/flex_srx_frame.sv
// Strobe-sampled serial frame receiver: start bit, NUM_BITS data bits, stop bit,
// held output word with ready/read handshake. SRX_PARITY_EN adds an even-parity bit.
module flex_srx_frame #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  flex_srx_frame_if.slave   bus
);
  localparam int CW = $clog2(NUM_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP, S_LOAD
  } state_t;

  state_t              r_state, w_next;
  logic [NUM_BITS-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]       r_cnt;
  logic [NUM_BITS-1:0] r_rx_data;
  logic                r_data_ready, r_ferr, r_oerr;
  logic                w_strobe, w_sin, w_last;
`ifdef SRX_PARITY_EN
  logic                r_par, r_perr;
`endif

  assign w_strobe = bus.shift_strobe;
  assign w_sin    = bus.serial_in;
  assign w_last   = (r_cnt == CW'(NUM_BITS-1));

  generate
    if (SHIFT_MSB) begin : g_msb
      assign w_shift_nxt = {r_shift[NUM_BITS-2:0], w_sin};
    end else begin : g_lsb
      assign w_shift_nxt = {w_sin, r_shift[NUM_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_strobe && !w_sin) w_next = S_DATA;
`ifdef SRX_PARITY_EN
      S_DATA:   if (w_strobe && w_last) w_next = S_PARITY;
      S_PARITY: if (w_strobe)           w_next = S_STOP;
`else
      S_DATA:   if (w_strobe && w_last) w_next = S_STOP;
`endif
      S_STOP:   if (w_strobe)           w_next = w_sin ? S_LOAD : S_IDLE;
      S_LOAD:                           w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_rx_data    <= '0;
      r_data_ready <= 1'b0;
      r_ferr       <= 1'b0;
      r_oerr       <= 1'b0;
`ifdef SRX_PARITY_EN
      r_par        <= 1'b0;
      r_perr       <= 1'b0;
`endif
    end else begin
      // A read clears status in any state; LOAD below overrides it.
      if (bus.data_read) begin
        r_data_ready <= 1'b0;
        r_oerr       <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (w_strobe && !w_sin) begin
          r_cnt  <= '0;
          r_ferr <= 1'b0;
        end
        S_DATA: if (w_strobe) begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + CW'(1);
        end
`ifdef SRX_PARITY_EN
        S_PARITY: if (w_strobe) r_par <= w_sin;
`endif
        S_STOP: if (w_strobe && !w_sin) r_ferr <= 1'b1;
        S_LOAD: begin
          r_rx_data    <= r_shift;
          r_data_ready <= 1'b1;
          // Unread word being replaced; a simultaneous read counts as consumed.
          r_oerr       <= r_data_ready & ~bus.data_read;
`ifdef SRX_PARITY_EN
          r_perr       <= (^r_shift) ^ r_par;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.data_ready    = r_data_ready;
  assign bus.framing_error = r_ferr;
  assign bus.overrun_error = r_oerr;
`ifdef SRX_PARITY_EN
  assign bus.parity_error  = r_perr;
`endif
endmodule

// File: tb/tb_flex_srx_frame.sv
// Bench for flex_srx_frame: an MSB-first and an LSB-first receiver share one line;
// a table of frames, hand-written corner sequences, then random frames vs a word-level model.
module tb_flex_srx_frame;
  logic clk = 1'b0;
  logic n_rst;
  logic strobe, sin, dread;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flex_srx_frame_if #(.NUM_BITS(8)) if1 ();
  flex_srx_frame_if #(.NUM_BITS(8)) if0 ();

  assign if1.shift_strobe = strobe;
  assign if1.serial_in    = sin;
  assign if1.data_read    = dread;
  assign if0.shift_strobe = strobe;
  assign if0.serial_in    = sin;
  assign if0.data_read    = dread;

  flex_srx_frame #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (.clk(clk), .n_rst(n_rst), .bus(if1));
  flex_srx_frame #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (.clk(clk), .n_rst(n_rst), .bus(if0));

  // Model: m_rx is the word in line order (first data bit = bit 7).
  logic [7:0] m_rx;
  logic       m_rdy, m_ferr, m_oerr, m_perr;
  logic       n1_rdy;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm);
    chk({nm, ".rx_msb"}, 32'(if1.rx_data), 32'(m_rx));
    chk({nm, ".rx_lsb"}, 32'(if0.rx_data), 32'(rev8(m_rx)));
    chk({nm, ".rdy"},  {30'd0, if1.data_ready,    if0.data_ready},    {30'd0, m_rdy, m_rdy});
    chk({nm, ".ferr"}, {30'd0, if1.framing_error, if0.framing_error}, {30'd0, m_ferr, m_ferr});
    chk({nm, ".oerr"}, {30'd0, if1.overrun_error, if0.overrun_error}, {30'd0, m_oerr, m_oerr});
`ifdef SRX_PARITY_EN
    chk({nm, ".perr"}, {30'd0, if1.parity_error,  if0.parity_error},  {30'd0, m_perr, m_perr});
`endif
  endtask

  task automatic model_reset();
    m_rx = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
  endtask

  // One strobed bit, then three unstrobed clocks with line noise.
  task automatic send_bit(input logic b);
    @(negedge clk); sin = b; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0; sin = 1'($urandom);
    repeat (2) begin @(negedge clk); sin = 1'($urandom); end
  endtask

  // Full frame; returns one clock after the load edge. rd_load pulses data_read in the LOAD cycle.
  task automatic send_frame(input logic [7:0] lb, input logic stopb, input logic par, input logic rd_load);
    send_bit(1'b0);
    m_ferr = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(lb[i]);
`ifdef SRX_PARITY_EN
    send_bit(par);
`endif
    @(negedge clk); sin = stopb; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0; sin = 1'b1; dread = rd_load;
    n1_rdy = if1.data_ready;
    @(negedge clk); dread = 1'b0;
    if (stopb) begin
      if (rd_load)    m_oerr = 1'b0;
      else if (m_rdy) m_oerr = 1'b1;
      m_rdy  = 1'b1;
      m_rx   = lb;
      m_perr = (^lb) ^ par;
    end else begin
      m_ferr = 1'b1;
      if (rd_load) begin m_rdy = 1'b0; m_oerr = 1'b0; end
    end
  endtask

  task automatic read_pulse();
    @(negedge clk); dread = 1'b1;
    @(negedge clk); dread = 1'b0;
    m_rdy = 1'b0; m_oerr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] lb;
    logic       stopb;
    logic       rd_load;
    logic       rd_after;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic       exp_rdy;
    logic       exp_ferr;
    logic       exp_oerr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hB2, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'hB2, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h1E, 1'b1, 1'b0, 1'b0, 8'h1E, 8'h78, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hC5, 1'b1, 1'b1, 1'b0, 8'hC5, 8'hA3, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1};

    n_rst = 1'b0; strobe = 1'b0; sin = 1'b1; dread = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all("reset");
    n_rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_frame(tbl[v].lb, tbl[v].stopb, ^tbl[v].lb, tbl[v].rd_load);
      chk($sformatf("tbl%0d.rx_msb", v), 32'(if1.rx_data), 32'(tbl[v].exp_msb));
      chk($sformatf("tbl%0d.rx_lsb", v), 32'(if0.rx_data), 32'(tbl[v].exp_lsb));
      chk($sformatf("tbl%0d.rdy", v),  32'(if1.data_ready),    32'(tbl[v].exp_rdy));
      chk($sformatf("tbl%0d.ferr", v), 32'(if1.framing_error), 32'(tbl[v].exp_ferr));
      chk($sformatf("tbl%0d.oerr", v), 32'(if1.overrun_error), 32'(tbl[v].exp_oerr));
      chk_all($sformatf("tbl%0d.model", v));
      if (tbl[v].rd_after) begin
        read_pulse();
        chk_all($sformatf("tbl%0d.read", v));
      end
    end

    // Mid-frame reset with rdy/oerr currently set.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk); n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all("midreset");
    n_rst = 1'b1;
    send_frame(8'hB2, 1'b1, 1'b0, 1'b0);
    chk("lat.before", 32'(n1_rdy), 32'd0);
    chk_all("after_reset");

    read_pulse();
    chk_all("read_clear");
    read_pulse();
    chk_all("read_idle");

    // Wrong parity still loads the word.
    send_frame(8'hB2, 1'b1, 1'b1, 1'b1);
    chk_all("parity_bad");
    send_frame(8'hB2, 1'b1, 1'b0, 1'b1);
    chk_all("parity_good");

    for (int it = 0; it < 60; it++) begin
      logic [7:0] lb;
      logic       stopb, rdl, par;
      lb    = 8'($urandom);
      stopb = ($urandom_range(0, 4) != 0);
      rdl   = ($urandom_range(0, 3) == 0);
      par   = (^lb) ^ ($urandom_range(0, 5) == 0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) send_bit(1'b1);
      send_frame(lb, stopb, par, rdl);
      chk_all($sformatf("rnd%0d", it));
      if ($urandom_range(0, 2) == 0) begin
        read_pulse();
        chk_all($sformatf("rnd%0d.read", it));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flex_srx_frame.md
Name: flex_srx_frame

Overview:
- Serial-to-parallel frame receiver; the receiving end of the flexible parallel-to-serial transmit path.
- Samples one line bit per shift_strobe, detects the start bit, and shifts in NUM_BITS data bits. It then checks the stop bit and presents the word on a held parallel register.
- A data_ready/data_read handshake hands the word to downstream logic, with framing and overrun status.

Parameters:
- NUM_BITS, 8, data bits per frame; legal range 2..32.
- SHIFT_MSB, 1, bit order on the line. 1 = first data bit received lands in rx_data[NUM_BITS-1]; 0 = first data bit lands in rx_data[0].

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- shift_strobe  input  1  single-cycle pulse marking a valid bit on serial_in.
- serial_in  input  1  serial line; idles high.
- data_read  input  1  single-cycle pulse; consumer has taken rx_data.
- rx_data  output  NUM_BITS  last complete received word, held until the next good frame.
- data_ready  output  1  rx_data holds an unread word.
- framing_error  output  1  last frame had stop bit = 0.
- overrun_error  output  1  an unread word was overwritten.

Behaviour:
- Reset: state IDLE, shift register 0, bit counter 0. rx_data = 0, data_ready = 0, framing_error = 0, overrun_error = 0.
- Reset mid-frame aborts the frame and discards partial data.
- Edges without shift_strobe never advance the frame FSM, except the LOAD state.
- FSM states and transitions:
  - IDLE: strobe with serial_in=0 → DATA, counter cleared, framing_error cleared. Strobe with serial_in=1 → stay in IDLE.
  - DATA: each strobe shifts serial_in into the shift register and increments the counter. The NUM_BITS-th strobe → STOP.
  - STOP: on strobe, serial_in=1 → LOAD. On strobe, serial_in=0 → framing_error <= 1, data discarded, rx_data/data_ready untouched, → IDLE.
  - LOAD: single cycle, independent of strobe. rx_data <= shift register, data_ready <= 1, → IDLE.
- Shift direction:
  - SHIFT_MSB=1: shift left, new bit into bit 0.
  - SHIFT_MSB=0: shift right, new bit into bit NUM_BITS-1.
- Latency: stop bit sampled at edge E; rx_data and data_ready update at edge E+1.
- Handshake:
  - data_read high at an edge clears data_ready and overrun_error.
  - data_read while data_ready=0 has no effect.
- Overrun: in LOAD, if data_ready=1 and data_read=0, overrun_error <= 1 and rx_data is overwritten with the new word.
- LOAD with data_read=1 in the same cycle: the load wins. data_ready stays 1 and overrun_error stays 0.
- A strobe arriving during LOAD is ignored; transmitters must supply at least one idle clock between the stop bit and the next start bit.
- framing_error is sticky until the next start bit is detected or reset.
- All outputs are registered.

Optional Feature:
- Macro: SRX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, consuming one strobe for an even-parity bit.
  - Adds output parity_error (1 bit, reset 0). In LOAD it is set if the XOR of the data bits and the parity bit is 1, otherwise cleared.
  - The word is still loaded when parity_error is set.
  - A frame occupies NUM_BITS+3 strobes.
- Undefined: no PARITY state and no parity_error port; a frame occupies NUM_BITS+2 strobes.

Test Plan (NUM_BITS=8, strobe every 4 clocks unless noted):
- Reset: assert n_rst after the 3rd data strobe of a frame → all outputs 0, FSM in IDLE. Next frame with data 0xB2 → received correctly.
- Nominal frame, SHIFT_MSB=1: line sequence 0,1,0,1,1,0,0,1,0,1. Required: rx_data=0xB2 and data_ready=1 exactly one clock after the stop strobe; framing_error=0, overrun_error=0.
- Nominal frame, SHIFT_MSB=0, same line sequence → rx_data=0x4D.
- Framing error: same sequence with stop bit 0 → framing_error=1, data_ready stays 0, rx_data keeps its prior value. Next start bit → framing_error=0.
- Overrun and handshake:
  - Frames 0xB2 then 0x5A with no data_read → rx_data=0x5A, data_ready=1, overrun_error=1.
  - data_read pulse → data_ready=0, overrun_error=0.
- Collision and parity:
  - data_read asserted exactly in the LOAD cycle → data_ready=1, overrun_error=0, rx_data = new word.
  - With SRX_PARITY_EN: data 0xB2 with parity bit 0 → parity_error=0; parity bit 1 → parity_error=1.
